// File: rtl/simmem_pkg.sv
// Shared widths and slot record for the simulated-memory write-response path.
// No logic; no latency; no backpressure.
package simmem_pkg;

    localparam int WriteRespBankAddrWidth = 4;
    localparam int DelayWidth             = 8;

    typedef struct packed {
        logic                              occupied;
        logic [WriteRespBankAddrWidth-1:0] id;
        logic [DelayWidth-1:0]             counter;
    } slot_t;

endpackage

// File: rtl/simmem_lowest_set_finder.sv
// Lowest-set-bit finder: returns index of the lowest set bit and whether any bit is set.
// Purely combinational, zero latency; no backpressure.
// With no bit set, the index reads 0 and the found flag is low.
module simmem_lowest_set_finder #(
    parameter  int Width = 8,
    localparam int IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] i_vec,
    output logic [IdxW-1:0]  o_idx,
    output logic             o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        // Scan downwards so the last hit written is the lowest index.
        for (int i = Width - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = IdxW'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simmem_delay_tracker.sv
// Holds (id, delay) entries in slots and releases each id once its countdown reaches zero.
// Release no earlier than T+1+D for an entry accepted in cycle T; outputs are register-only.
// in_ready_o drops when all slots are full; a stalled release locks its slot until handshake.
module simmem_delay_tracker
    import simmem_pkg::*;
#(
    parameter int NumSlots = 8,
    parameter int IdWidth  = WriteRespBankAddrWidth,
    parameter int CntWidth = DelayWidth
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [IdWidth-1:0]          local_id_i,
    input  logic [CntWidth-1:0]         delay_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    output logic [IdWidth-1:0]          release_id_o,
    output logic                        release_valid_o,
    input  logic                        release_ready_i,
    output logic [$clog2(NumSlots):0]   occupancy_o
);

    localparam int IdxW = $clog2(NumSlots);
    localparam int OccW = IdxW + 1;

    // Same layout as simmem_pkg::slot_t, sized by this instance's parameters.
    typedef struct packed {
        logic                occupied;
        logic [IdWidth-1:0]  id;
        logic [CntWidth-1:0] counter;
    } trk_slot_t;

    trk_slot_t         r_slots [NumSlots];
    logic              r_locked;
    logic [IdxW-1:0]   r_lock_idx;
    logic [OccW-1:0]   r_occ;

    logic [NumSlots-1:0] w_free_vec;
    logic [NumSlots-1:0] w_exp_vec;
    logic [IdxW-1:0]     w_free_idx;
    logic [IdxW-1:0]     w_exp_idx;
    logic [IdxW-1:0]     w_sel_idx;
    logic                w_free_found;
    logic                w_exp_found;
    logic                w_rel_vld;
    logic                w_accept;
    logic                w_release;

    always_comb begin
        w_free_vec = '0;
        w_exp_vec  = '0;
        for (int i = 0; i < NumSlots; i++) begin
            w_free_vec[i] = ~r_slots[i].occupied;
            w_exp_vec[i]  = r_slots[i].occupied && (r_slots[i].counter == '0);
        end
    end

    simmem_lowest_set_finder #(.Width(NumSlots)) u_free_finder (
        .i_vec   (w_free_vec),
        .o_idx   (w_free_idx),
        .o_found (w_free_found)
    );

    simmem_lowest_set_finder #(.Width(NumSlots)) u_exp_finder (
        .i_vec   (w_exp_vec),
        .o_idx   (w_exp_idx),
        .o_found (w_exp_found)
    );

    // A locked slot stays expired until its handshake, so it alone keeps valid high.
    assign w_sel_idx       = r_locked ? r_lock_idx : w_exp_idx;
    assign w_rel_vld       = r_locked | w_exp_found;
    assign release_valid_o = w_rel_vld;
    assign release_id_o    = w_rel_vld ? r_slots[w_sel_idx].id : '0;
    assign in_ready_o      = w_free_found;
    assign occupancy_o     = r_occ;

    assign w_accept  = in_valid_i & w_free_found;
    assign w_release = w_rel_vld & release_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumSlots; i++) begin
                r_slots[i] <= '0;
            end
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
            r_occ      <= '0;
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                if (w_release && (w_sel_idx == IdxW'(i))) begin
                    r_slots[i].occupied <= 1'b0;
                end else if (w_accept && (w_free_idx == IdxW'(i))) begin
                    r_slots[i].occupied <= 1'b1;
                    r_slots[i].id       <= local_id_i;
                    r_slots[i].counter  <= delay_i;
                end else if (r_slots[i].occupied && (r_slots[i].counter != '0)) begin
                    r_slots[i].counter <= r_slots[i].counter - CntWidth'(1);
                end
            end

            if (w_release) begin
                r_locked <= 1'b0;
            end else if (w_rel_vld) begin
                r_locked   <= 1'b1;
                r_lock_idx <= w_sel_idx;
            end

            r_occ <= r_occ + OccW'(w_accept) - OccW'(w_release);
        end
    end

endmodule

// File: tb/tb_simmem_delay_tracker.sv
// Directed bench for simmem_delay_tracker: vector table plus multi-cycle corner sequences.
module tb_simmem_delay_tracker;

    logic       clk;
    logic       rst_n;
    logic [3:0] local_id;
    logic [7:0] delay;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] rel_id;
    logic       rel_vld;
    logic       rel_rdy;
    logic [3:0] occ;

    int checks = 0;
    int errors = 0;

    simmem_delay_tracker dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .local_id_i      (local_id),
        .delay_i         (delay),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .release_id_o    (rel_id),
        .release_valid_o (rel_vld),
        .release_ready_i (rel_rdy),
        .occupancy_o     (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [3:0] id;
        logic [7:0] dly;
        logic       rdy;
        logic       e_inrdy;
        logic       e_rv;
        logic [3:0] e_rid;
        logic [3:0] e_occ;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] id, input logic [7:0] d);
        in_valid = 1'b1;
        local_id = id;
        delay    = d;
        tick();
        in_valid = 1'b0;
        local_id = '0;
        delay    = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic latency_test(input logic [3:0] id, input logic [7:0] d, input int exp_lat, input string nm);
        int n;
        rel_rdy = 1'b1;
        push(id, d);
        n = 1;
        while (!rel_vld && n < 400) begin
            tick();
            n++;
        end
        chk({nm, "_latency"}, n, exp_lat);
        chk({nm, "_id"}, rel_id, id);
        chk({nm, "_occ_busy"}, occ, 1);
        tick();
        chk({nm, "_occ_after"}, occ, 0);
        chk({nm, "_vld_after"}, rel_vld, 0);
    endtask

    initial begin
        logic [3:0] exp_seq [8];
        int         got;
        int         n;
        int         stale;

        //            vld id dly rdy  inrdy rv rid occ
        vecs[0]  = '{1'b1, 4'd3, 8'd0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0};
        vecs[1]  = '{1'b1, 4'd6, 8'd0, 1'b1, 1'b1, 1'b1, 4'd3, 4'd1};
        vecs[2]  = '{1'b1, 4'd7, 8'd0, 1'b1, 1'b1, 1'b1, 4'd6, 4'd1};
        vecs[3]  = '{1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 1'b1, 4'd7, 4'd1};
        vecs[4]  = '{1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0};
        vecs[5]  = '{1'b1, 4'd9, 8'd2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
        vecs[6]  = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1};
        vecs[7]  = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1};
        vecs[8]  = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b1, 4'd9, 4'd1};
        vecs[9]  = '{1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 1'b1, 4'd9, 4'd1};
        vecs[10] = '{1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0};

        exp_seq = '{4'd9, 4'd14, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

        in_valid = 1'b0;
        local_id = '0;
        delay    = '0;
        rel_rdy  = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rel_vld", rel_vld, 0);
        chk("rst_rel_id", rel_id, 0);
        chk("rst_occ", occ, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Back-to-back zero-delay entries, then a short delay with one stalled cycle.
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("tbl%0d_in_ready", i), in_ready, vecs[i].e_inrdy);
            chk($sformatf("tbl%0d_rel_vld", i), rel_vld, vecs[i].e_rv);
            chk($sformatf("tbl%0d_rel_id", i), rel_id, vecs[i].e_rid);
            chk($sformatf("tbl%0d_occ", i), occ, vecs[i].e_occ);
            in_valid = vecs[i].vld;
            local_id = vecs[i].id;
            delay    = vecs[i].dly;
            rel_rdy  = vecs[i].rdy;
            tick();
        end
        in_valid = 1'b0;

        // Same-cycle accept and release at occupancy 3.
        rel_rdy = 1'b1;
        push(4'd1, 8'd200);
        push(4'd2, 8'd200);
        push(4'd4, 8'd0);
        chk("same_occ_before", occ, 3);
        chk("same_rel_vld", rel_vld, 1);
        chk("same_rel_id", rel_id, 4);
        push(4'd11, 8'd200);
        chk("same_occ_after", occ, 3);
        chk("same_vld_after", rel_vld, 0);

        // Five pending entries with a locked release, then asynchronous reset.
        rel_rdy = 1'b0;
        push(4'd12, 8'd0);
        push(4'd10, 8'd200);
        chk("rst5_occ", occ, 5);
        chk("rst5_rel_id", rel_id, 12);
        tick();
        chk("rst5_locked_id", rel_id, 12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_rel_vld", rel_vld, 0);
        chk("arst_rel_id", rel_id, 0);
        chk("arst_occ", occ, 0);
        tick();
        rst_n   = 1'b1;
        rel_rdy = 1'b1;
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            if (rel_vld) stale++;
            tick();
        end
        chk("arst_no_stale", stale, 0);
        chk("arst_occ_after", occ, 0);

        latency_test(4'd5, 8'd30, 31, "d30");

        // Fill all slots, release slot 0, refill it while slot 1 is locked.
        rel_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill%0d_in_ready", i), in_ready, 1);
            push(4'(i + 8), 8'd100);
        end
        chk("full_in_ready", in_ready, 0);
        chk("full_occ", occ, 8);
        in_valid = 1'b1;
        local_id = 4'd15;
        delay    = 8'd0;
        tick();
        in_valid = 1'b0;
        chk("full_hold_occ", occ, 8);
        n = 0;
        while (!rel_vld && n < 200) begin
            tick();
            n++;
        end
        chk("full_first_vld", rel_vld, 1);
        chk("full_first_id", rel_id, 8);
        rel_rdy = 1'b1;
        tick();
        rel_rdy = 1'b0;
        chk("full_reopen_in_ready", in_ready, 1);
        chk("full_reopen_occ", occ, 7);
        push(4'd14, 8'd0);
        chk("full_locked_id", rel_id, 9);
        rel_rdy = 1'b1;
        got = 0;
        n = 0;
        while (got < 8 && n < 100) begin
            if (rel_vld) begin
                chk($sformatf("drain%0d_id", got), rel_id, exp_seq[got]);
                got++;
            end
            tick();
            n++;
        end
        chk("drain_count", got, 8);
        chk("drain_occ", occ, 0);

        // Slot 4 stalls for 10 cycles while slot 1 expires underneath it.
        rel_rdy = 1'b0;
        push(4'd1, 8'd200);
        push(4'd2, 8'd5);
        push(4'd3, 8'd200);
        push(4'd4, 8'd200);
        push(4'd6, 8'd0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("lock%0d_vld", i), rel_vld, 1);
            chk($sformatf("lock%0d_id", i), rel_id, 6);
            tick();
        end
        rel_rdy = 1'b1;
        chk("lock_hs_id", rel_id, 6);
        tick();
        rel_rdy = 1'b0;
        chk("lock_next_vld", rel_vld, 1);
        chk("lock_next_id", rel_id, 2);
        chk("lock_next_occ", occ, 4);
        do_reset();

        latency_test(4'd7, 8'd255, 256, "dmax");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simmem_delay_tracker.md
# simmem_delay_tracker

Consumes the (local identifier, delay) pairs produced by the delay calculator, holds each one in a slot with a private countdown counter, and releases the local identifier downstream once its delay has fully elapsed. It sits between the delay calculator and the write-response bank release logic. It is the point where the simulated memory latency is actually enforced.

## Interface
Parameters:
- NumSlots, 8, number of concurrently tracked entries (power of two, ≥2)
- IdWidth, simmem_pkg::WriteRespBankAddrWidth, local identifier width
- CntWidth, simmem_pkg::DelayWidth, delay and counter width

Ports:
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- local_id_i  in  IdWidth  identifier to track
- delay_i  in  CntWidth  delay in cycles, unsigned
- in_valid_i  in  1  input entry valid
- in_ready_o  out  1  at least one free slot
- release_id_o  out  IdWidth  identifier whose delay expired
- release_valid_o  out  1  release_id_o valid
- release_ready_i  in  1  downstream accepts release
- occupancy_o  out  $clog2(NumSlots)+1  number of occupied slots

## Operation
- Per slot state: occupied bit, stored id, counter (CntWidth).
- Accept: in_valid_i && in_ready_o. The lowest-index free slot is allocated: occupied←1, id←local_id_i, counter←delay_i.
- Countdown: every cycle, each occupied slot with counter≠0 decrements by 1. Counter never wraps and stays at 0.
- Expired slot: occupied && counter==0.
- Output selection: while unlocked, present the lowest-index expired slot. If release_valid_o && !release_ready_i, lock that slot index. While locked, present the locked slot regardless of other expiries. Lock clears on handshake.
- Release handshake: release_valid_o && release_ready_i frees the presented slot (occupied←0) at the clock edge.
- in_ready_o depends only on registered occupancy. A slot freed in cycle T is allocatable from T+1.
- Simultaneous accept and release in the same cycle always target different slots and both take effect. occupancy_o is then unchanged.
- release_id_o = 0 when release_valid_o=0.
- Input with in_valid_i=1 while in_ready_o=0 is not consumed. The upstream holds it.

## Timing
- Reset values: all slots free, counters 0, lock clear. in_ready_o=1, release_valid_o=0, release_id_o=0, occupancy_o=0.
- Entry accepted in cycle T with delay D: counter=D in T+1. release_valid_o may assert no earlier than cycle T+1+D. D=0 gives T+1.
- Release is delayed beyond T+1+D only by backpressure or by a lower-index or locked slot winning arbitration. The counter stays at 0 meanwhile.
- release_valid_o, release_id_o and in_ready_o are combinational from registers only; there is no in→out combinational path. Once asserted, release_valid_o and release_id_o stay stable until the handshake.
- Full: occupancy_o=NumSlots gives in_ready_o=0. A release in that cycle raises in_ready_o in the next cycle.
- Asynchronous reset mid-operation discards all entries immediately, including a locked release, and outputs go to their reset values.
- Max delay 2^CntWidth−1 must be handled exactly, with no overflow.

## Structure
- simmem_pkg holds WriteRespBankAddrWidth, DelayWidth, and the slot struct typedef (occupied, id, counter).
- Sub-module simmem_lowest_set_finder: parameterized lowest-set-bit finder (vector→index+found). It is instantiated twice, for free-slot allocation and for expired-slot selection.

## Test plan
- Single entry, id=5, D=30, release_ready_i=1: release_valid_o with id 5 exactly 31 cycles after accept. occupancy_o goes 1→0.
- D=0, id=3: release in the cycle after accept. Back-to-back D=0 entries release one per cycle.
- Fill all 8 slots with D=100: in_ready_o=0 while full. Release one slot → in_ready_o=1 next cycle, and the new entry takes the freed index.
- Slot 4 expires with release_ready_i=0 for 10 cycles while slot 1 expires meanwhile: id of slot 4 is held stable, then slot 1 releases in the cycle after the handshake.
- Same-cycle accept and release at occupancy 3: both succeed and occupancy_o stays 3.
- Reset asserted with 5 entries pending and a locked release: all outputs return to reset values asynchronously, and no stale release appears after deassertion.
